// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-FF input synchroniser, false-start rejection,
// parity/framing/break/overrun detection and a valid/ready output holding register.
module uart_rx_cfg #(
    parameter int clk_per_bit = 5280,
    parameter int data_bits   = 8,
    parameter int parity_mode = 0,
    parameter int stop_bits   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic [data_bits-1:0] rx_rec,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 rx_overrun
);

    localparam int CNT_W = $clog2(clk_per_bit);
    localparam int IDX_W = $clog2(data_bits);

    localparam logic [CNT_W-1:0] HALF      = CNT_W'((clk_per_bit - 1) / 2);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(clk_per_bit - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(data_bits - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(stop_bits - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [data_bits-1:0] shift;
    logic                 par_err_p;
    logic                 frame_err_p;
    logic                 tail_low;

    logic                 par_exp;
    logic                 accept;

    assign par_exp = (^shift) ^ (parity_mode == 2);
    assign accept  = !rx_valid || rx_ready;

    // tail_low tracks whether the parity bit and every stop bit so far were low,
    // which together with an all-zero word marks a break condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            par_err_p   <= 1'b0;
            frame_err_p <= 1'b0;
            tail_low    <= 1'b1;
            rx_rec      <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            rx_meta    <= rx_serial;
            rx_s       <= rx_meta;
            rx_overrun <= 1'b0;

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state       <= DATA;
                            par_err_p   <= 1'b0;
                            frame_err_p <= 1'b0;
                            tail_low    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        if (idx == DATA_LAST) begin
                            idx   <= '0;
                            state <= (parity_mode != 0) ? PARITY : STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        par_err_p <= (rx_s != par_exp);
                        tail_low  <= tail_low & ~rx_s;
                        state     <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // The last stop sample commits straight from here; the line is
                // still high for half a bit, so IDLE does not re-trigger on it.
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (idx == STOP_LAST) begin
                            idx   <= '0;
                            state <= IDLE;
                            if (accept) begin
                                rx_rec     <= shift;
                                rx_valid   <= 1'b1;
                                parity_err <= par_err_p;
                                frame_err  <= frame_err_p | ~rx_s;
                                break_det  <= (shift == '0) & tail_low & ~rx_s;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            idx         <= idx + 1'b1;
                            frame_err_p <= frame_err_p | ~rx_s;
                            tail_low    <= tail_low & ~rx_s;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 instance and an 8E2 instance, both at
// 16 clocks per bit, fed directed frames; a monitor pops expectations on each handshake.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0] rec;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rx_b;
    logic       ready_a, ready_b;
    logic [7:0] rec_a, rec_b;
    logic       valid_a, valid_b;
    logic       perr_a, perr_b;
    logic       ferr_a, ferr_b;
    logic       brk_a, brk_b;
    logic       ovr_a, ovr_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_a = 0;
    int   ovr_cnt_a = 0;
    int   ovr_cnt_b = 0;

    uart_rx_cfg #(
        .clk_per_bit(CPB),
        .data_bits  (8),
        .parity_mode(0),
        .stop_bits  (1)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_a),
        .rx_rec    (rec_a),
        .rx_valid  (valid_a),
        .rx_ready  (ready_a),
        .parity_err(perr_a),
        .frame_err (ferr_a),
        .break_det (brk_a),
        .rx_overrun(ovr_a)
    );

    uart_rx_cfg #(
        .clk_per_bit(CPB),
        .data_bits  (8),
        .parity_mode(1),
        .stop_bits  (2)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_b),
        .rx_rec    (rec_b),
        .rx_valid  (valid_b),
        .rx_ready  (ready_b),
        .parity_err(perr_b),
        .frame_err (ferr_b),
        .break_det (brk_b),
        .rx_overrun(ovr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every handshake pops one expected word per receiver.
    always @(negedge clk) begin
        if (valid_a && ready_a) begin
            hs_a++;
            if (q_a.size() == 0) begin
                checkOutput("8N1 unexpected word", q_a.size(), 1);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                checkOutput("8N1 rx_rec", rec_a, e.rec);
                checkOutput("8N1 parity_err", perr_a, e.perr);
                checkOutput("8N1 frame_err", ferr_a, e.ferr);
                checkOutput("8N1 break_det", brk_a, e.brk);
            end
        end
        if (valid_b && ready_b) begin
            if (q_b.size() == 0) begin
                checkOutput("8E2 unexpected word", q_b.size(), 1);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                checkOutput("8E2 rx_rec", rec_b, e.rec);
                checkOutput("8E2 parity_err", perr_b, e.perr);
                checkOutput("8E2 frame_err", ferr_b, e.ferr);
                checkOutput("8E2 break_det", brk_b, e.brk);
            end
        end
        if (ovr_a) ovr_cnt_a++;
        if (ovr_b) ovr_cnt_b++;
    end

    task automatic holdA(input logic b, input int cycles);
        rx_a = b;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic holdB(input logic b, input int cycles);
        rx_b = b;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic sendA(input logic [7:0] d, input logic stop);
        holdA(1'b0, CPB);
        for (int i = 0; i < 8; i++) holdA(d[i], CPB);
        holdA(stop, CPB);
        rx_a = 1'b1;
    endtask

    task automatic sendB(input logic [7:0] d, input logic par);
        holdB(1'b0, CPB);
        for (int i = 0; i < 8; i++) holdB(d[i], CPB);
        holdB(par, CPB);
        holdB(1'b1, 2 * CPB);
    endtask

    task automatic expectA(input logic [7:0] rec, input logic perr, input logic ferr, input logic brk);
        q_a.push_back({rec, perr, ferr, brk});
    endtask

    task automatic expectB(input logic [7:0] rec, input logic perr, input logic ferr, input logic brk);
        q_b.push_back({rec, perr, ferr, brk});
    endtask

    task automatic idle(input int bits);
        repeat (bits * CPB) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        int t0;
        int tv;
        int hs_before;

        $display("[TB] 8E2 parity frames");
        expectB(8'h07, 1'b0, 1'b0, 1'b0);
        sendB(8'h07, 1'b1);
        expectB(8'h07, 1'b1, 1'b0, 1'b0);
        sendB(8'h07, 1'b0);
        idle(2);

        // Drive after edge e: rx_s low is seen at edge e+3 (detection); the first
        // word is sampled high by edge detection+153, i.e. visible after e+155.
        $display("[TB] 8N1 back-to-back 0xA5 0x3C");
        expectA(8'hA5, 1'b0, 1'b0, 1'b0);
        expectA(8'h3C, 1'b0, 1'b0, 1'b0);
        t0 = cyc;
        tv = -1;
        fork
            begin
                sendA(8'hA5, 1'b1);
                sendA(8'h3C, 1'b1);
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (valid_a) begin
                        tv = cyc;
                        break;
                    end
                end
                @(negedge clk);
                checkOutput("8N1 valid pulse width", valid_a, 0);
            end
        join
        checkOutput("8N1 first valid latency", tv - t0, 155);
        idle(2);

        $display("[TB] false start then 0x81");
        hs_before = hs_a;
        holdA(1'b0, 5);
        rx_a = 1'b1;
        idle(3);
        checkOutput("glitch produced no word", hs_a, hs_before);
        expectA(8'h81, 1'b0, 1'b0, 1'b0);
        sendA(8'h81, 1'b1);
        idle(3);

        $display("[TB] framing error on 0x55");
        expectA(8'h55, 1'b0, 1'b1, 1'b0);
        sendA(8'h55, 1'b0);
        idle(3);

        // After the break commits, the still-low line restarts a frame whose bit 0
        // lands in the low tail and bits 1..7 after release, giving 0xFE.
        $display("[TB] break: line low for 12 bit times");
        expectA(8'h00, 1'b0, 1'b1, 1'b1);
        expectA(8'hFE, 1'b0, 1'b0, 1'b0);
        holdA(1'b0, 12 * CPB);
        rx_a = 1'b1;
        idle(10);

        $display("[TB] backpressure 0x11 then 0x22");
        ready_a = 1'b0;
        expectA(8'h11, 1'b0, 1'b0, 1'b0);
        sendA(8'h11, 1'b1);
        sendA(8'h22, 1'b1);
        idle(1);
        @(negedge clk);
        checkOutput("stalled rx_valid", valid_a, 1);
        checkOutput("stalled rx_rec", rec_a, 8'h11);
        checkOutput("overrun pulses after 0x22", ovr_cnt_a, 1);
        @(posedge clk);
        #1;
        ready_a = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("valid drops after accept", valid_a, 0);
        idle(1);

        $display("[TB] reset during data bit 4 of 0xF0");
        holdA(1'b0, CPB);
        for (int i = 0; i < 4; i++) holdA(1'b0, CPB);
        holdA(1'b1, CPB / 2);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset rx_valid", valid_a, 0);
        checkOutput("post-reset rx_rec", rec_a, 0);
        checkOutput("post-reset parity_err", perr_a, 0);
        checkOutput("post-reset frame_err", ferr_a, 0);
        checkOutput("post-reset break_det", brk_a, 0);
        checkOutput("post-reset rx_overrun", ovr_a, 0);
        idle(4);
        expectA(8'h5A, 1'b0, 1'b0, 1'b0);
        sendA(8'h5A, 1'b1);
    endtask

    initial begin
        rst     = 1'b1;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        ready_a = 1'b1;
        ready_b = 1'b1;
        repeat (3) @(posedge clk);
        rx_a = 1'b0;
        @(negedge clk);
        checkOutput("reset rx_valid", valid_a, 0);
        checkOutput("reset rx_rec", rec_a, 0);
        checkOutput("reset frame_err", ferr_a, 0);
        checkOutput("reset rx_overrun", ovr_a, 0);
        @(posedge clk);
        #1;
        rx_a = 1'b1;
        rst  = 1'b0;
        idle(1);

        applyStimulus();

        idle(4);
        checkOutput("8N1 words not delivered", q_a.size(), 0);
        checkOutput("8E2 words not delivered", q_b.size(), 0);
        checkOutput("8N1 total overrun pulses", ovr_cnt_a, 1);
        checkOutput("8E2 total overrun pulses", ovr_cnt_b, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, the successor to the fixed 8N1 receiver. It adds:
- configurable data width, parity and stop-bit count;
- input synchronisation and false-start rejection;
- framing, parity, break and overrun detection;
- a valid/ready output handshake so downstream logic can stall.

It sits between the board RX pin and the command/FIFO logic.

## Interface
- `clk_per_bit`, 5280: system clocks per bit; legal range ≥ 4.
- `data_bits`, 8: data bits per frame; legal range 5–9.
- `parity_mode`, 0: 0 = none, 1 = even, 2 = odd.
- `stop_bits`, 1: 1 or 2.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rx_serial`  in  1  asynchronous UART line; idles high.
- `rx_rec`  out  data_bits  received word, LSB first on the line.
- `rx_valid`  out  1  `rx_rec` and the error flags are valid.
- `rx_ready`  in  1  consumer accepts the word when `rx_valid && rx_ready`.
- `parity_err`  out  1  parity mismatch on the held word; 0 when `parity_mode` = 0.
- `frame_err`  out  1  a stop bit was sampled low on the held word.
- `break_det`  out  1  held word is all zeros, with parity (if any) and every stop bit sampled low.
- `rx_overrun`  out  1  one-cycle pulse: a completed frame was dropped.

## Operation
- `rx_serial` passes through a 2-FF synchroniser. Both stages reset to 1. All sampling uses the second stage, `rx_s`.
- Bit counter:
  - width is `$clog2(clk_per_bit)`;
  - it resets to 0 on every state change;
  - `H = (clk_per_bit-1)/2`, using integer division.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: counter = 0, bit index = 0. If `rx_s` = 0, go to START.
- START: count up to `H`. At `H`, sample `rx_s`:
  - if 1, it is a glitch; return to IDLE and produce no output and no flags;
  - if 0, go to DATA.
- DATA: at count = `clk_per_bit-1`, sample into shift bit[index] and increment the index.
  - After bit `data_bits-1`: go to PARITY if `parity_mode` ≠ 0, otherwise go to STOP.
- PARITY: sample after one bit period. The expected bit is the XOR of the data bits, inverted for odd parity. A mismatch sets the pending `parity_err`.
- STOP: sample after each bit period, `stop_bits` times. Any 0 sets the pending `frame_err`.
  - After the last sample: commit the frame and go straight to IDLE. There is no DONE state.
  - The line is still high for half a bit here, so IDLE does not re-trigger.
- Commit rules:
  - If `rx_valid` = 0, or `rx_ready` = 1 in the same cycle: load `rx_rec` and all three error flags, and set `rx_valid` to 1.
  - Otherwise: keep the held word and flags unchanged, drop the new frame, and pulse `rx_overrun` for one cycle.
- `rx_valid` clears on the cycle after `rx_valid && rx_ready`, unless a commit lands in that same cycle.
- `rx_rec` and the flags are stable while `rx_valid` = 1 and not yet accepted.
- Errored frames are still delivered, flagged. The consumer decides what to do with them.
- Reset:
  - all outputs go to 0, except `rx_rec` which also goes to 0;
  - the FSM goes to IDLE and both synchroniser stages go to 1;
  - a frame in progress is discarded silently, with no flag.
  - After reset, the receiver needs a high-to-low edge on `rx_s` to start a frame. A line held low through reset starts a frame as soon as `rx_s` sees 0.

## Timing
- Cycle numbering:
  - cycle 0 is the edge at which IDLE sees `rx_s` = 0;
  - `rx_s` lags a `rx_serial` transition by 2 clocks.
- START sample happens at cycle `1+H`.
- Sample k (k = 1..N) happens at cycle `1+H+k·clk_per_bit`, where `N = data_bits + (parity_mode≠0) + stop_bits`.
- `rx_valid` is high starting at cycle `2+H+N·clk_per_bit`.
- Back-to-back frames with no idle gap are received without loss, provided the consumer drains each word within one frame time.
- `rx_ready` may be held high permanently; `rx_valid` is then a single-cycle pulse per frame.

## Test plan
All scenarios use `clk_per_bit` = 16.
- Defaults (8N1): send 0xA5, then 0x3C back-to-back, with `rx_ready` = 1. Required: two 1-cycle `rx_valid` pulses, `rx_rec` = 0xA5 then 0x3C, no flags. The first pulse lands at cycle 2+7+9·16 after detection.
- `parity_mode` = 1 (even), `stop_bits` = 2: send 0x07 with the correct parity bit = 1 → `rx_rec` = 0x07, `parity_err` = 0. Send 0x07 with parity bit 0 → `parity_err` = 1.
- Framing and break:
  - 0x55 with its stop bit driven low → `frame_err` = 1, `rx_rec` = 0x55;
  - line held low for 12 bit times → `rx_rec` = 0x00, `frame_err` = 1, `break_det` = 1.
- False start: a 5-clock low glitch on `rx_serial` → FSM returns to IDLE, no `rx_valid`. A valid 0x81 that follows is received correctly.
- Backpressure: hold `rx_ready` = 0 while sending 0x11 then 0x22.
  - `rx_valid` stays 1 with `rx_rec` = 0x11.
  - `rx_overrun` pulses once when 0x22 completes.
  - Raising `rx_ready` accepts 0x11, then `rx_valid` drops.
- Reset mid-frame: assert `rst` during data bit 4 of 0xF0 → all outputs 0, no `rx_valid`. A subsequent 0x5A is received correctly.
